// File: rtl/clk_period_meter_pkg.sv
// rtl/clk_period_meter_pkg.sv - shared state encodings and default counter width for the period meter
package clk_period_meter_pkg;

  localparam int CW_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_TIMEOUT = 2'd2
  } state_e;

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - multi-stage synchroniser with rising-edge detect on the synchronised level
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic inClk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  // shift the raw input through the chain; prev remembers last synchronised level
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // chain and prev flops clear asynchronously so no edge is seen out of reset
  always_ff @(posedge inClk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q    = sync_q[SYNC_STAGES-1];
  assign rise = q & ~prev_q;

endmodule

// File: rtl/clk_period_meter.sv
// rtl/clk_period_meter.sv - rise-to-rise period meter with sticky timeout; duty measurement under CLK_METER_DUTY_EN
module clk_period_meter
  import clk_period_meter_pkg::*;
#(
  parameter int CW          = CW_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic          inClk,
  input  logic          reset,
  input  logic          sigIn,
  output logic [CW-1:0] period,
  output logic          periodValid,
  output logic          timeout,
  output logic [CW-1:0] highTime
);

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic sync_out;
  logic rise;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] period_q, period_d;
  logic          valid_q, valid_d;
  logic          timeout_q, timeout_d;
`ifdef CLK_METER_DUTY_EN
  logic [CW-1:0] hcnt_q, hcnt_d;
  logic [CW-1:0] high_q, high_d;
`else
  logic          unused_sync_out;
  assign unused_sync_out = sync_out;
`endif

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .inClk (inClk),
    .reset (reset),
    .d     (sigIn),
    .q     (sync_out),
    .rise  (rise)
  );

  // FSM next-state: a rise always restarts the count; publish only when a valid interval ended
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;
`ifdef CLK_METER_DUTY_EN
    hcnt_d    = hcnt_q;
    high_d    = high_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          cnt_d   = CNT_ONE;
`ifdef CLK_METER_DUTY_EN
          hcnt_d  = CNT_ONE;
`endif
          state_d = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        if (rise) begin
          period_d = cnt_q;
          valid_d  = 1'b1;
          cnt_d    = CNT_ONE;
`ifdef CLK_METER_DUTY_EN
          high_d   = hcnt_q;
          hcnt_d   = CNT_ONE;
`endif
        end else if (cnt_q == CNT_MAX) begin
          timeout_d = 1'b1;
          state_d   = ST_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
`ifdef CLK_METER_DUTY_EN
          if (sync_out && (hcnt_q != CNT_MAX)) begin
            hcnt_d = hcnt_q + CNT_ONE;
          end
`endif
        end
      end
      ST_TIMEOUT: begin
        if (rise) begin
          timeout_d = 1'b0;
          cnt_d     = CNT_ONE;
`ifdef CLK_METER_DUTY_EN
          hcnt_d    = CNT_ONE;
`endif
          state_d   = ST_MEASURE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // state, counters and registered outputs; reset discards any partial measurement
  always_ff @(posedge inClk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
`ifdef CLK_METER_DUTY_EN
      hcnt_q    <= '0;
      high_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
`ifdef CLK_METER_DUTY_EN
      hcnt_q    <= hcnt_d;
      high_q    <= high_d;
`endif
    end
  end

  assign period      = period_q;
  assign periodValid = valid_q;
  assign timeout     = timeout_q;
`ifdef CLK_METER_DUTY_EN
  assign highTime    = high_q;
`else
  assign highTime    = '0;
`endif

endmodule

// File: tb/tb_clk_period_meter.sv
// tb/tb_clk_period_meter.sv - directed self-checking bench for clk_period_meter
module tb_clk_period_meter;

`ifdef CLK_METER_DUTY_EN
  localparam int DUTY = 1;
`else
  localparam int DUTY = 0;
`endif

  logic       inClk;
  logic       reset;
  logic       sigIn;
  logic [7:0] period;
  logic       periodValid;
  logic       timeout;
  logic [7:0] highTime;

  int n_tests = 0;
  int n_fail  = 0;

  int cyc         = 0;
  int strobes     = 0;
  int last_cyc    = 0;
  int gap         = 0;
  int last_period = 0;
  int last_high   = 0;
  int dbl_cnt     = 0;
  int tmo_cycles  = 0;
  bit pv_prev     = 0;

  int s0;
  int t0;

  clk_period_meter dut (
    .inClk       (inClk),
    .reset       (reset),
    .sigIn       (sigIn),
    .period      (period),
    .periodValid (periodValid),
    .timeout     (timeout),
    .highTime    (highTime)
  );

  initial inClk = 1'b0;
  always #5 inClk = ~inClk;

  always @(posedge inClk) cyc <= cyc + 1;

  // strobe / timeout monitor sampled on the falling edge
  always @(negedge inClk) begin
    if (periodValid) begin
      if (pv_prev) dbl_cnt++;
      if (strobes > 0) gap = cyc - last_cyc;
      last_cyc    = cyc;
      strobes++;
      last_period = int'(period);
      last_high   = int'(highTime);
    end
    pv_prev = periodValid;
    if (timeout) tmo_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge inClk);
      #1;
    end
  endtask

  task automatic wave(input int hp, input int n);
    for (int i = 0; i < n; i++) begin
      sigIn = 1'b1;
      tick(hp);
      sigIn = 1'b0;
      tick(hp);
    end
  endtask

  initial begin
    reset = 1'b0;
    sigIn = 1'b0;

    // 1: reset held while sigIn toggles
    tick(2);
    for (int i = 0; i < 8; i++) begin
      sigIn = ~sigIn;
      tick(3);
    end
    check("rst_period", period, 0);
    check("rst_high", highTime, 0);
    check("rst_timeout", timeout, 0);
    check("rst_strobes", strobes, 0);
    sigIn = 1'b0;
    tick(4);
    reset = 1'b1;
    tick(20);
    check("post_rst_period", period, 0);
    check("post_rst_strobes", strobes, 0);

    // 2: half-period 5 -> period 10, first rise silent
    wave(5, 4);
    check("p10_strobes", strobes, 3);
    check("p10_period", last_period, 10);
    check("p10_high", last_high, DUTY ? 5 : 0);
    check("p10_gap", gap, 10);

    // 3: switch to half-period 7 at a rise
    s0 = strobes;
    wave(7, 3);
    check("p14_strobes", strobes - s0, 3);
    check("p14_period", last_period, 14);
    check("p14_high", last_high, DUTY ? 7 : 0);
    check("p14_gap", gap, 14);

    // 4: timeout after period 10, then recovery
    wave(5, 1);
    sigIn = 1'b1;
    tick(5);
    sigIn = 1'b0;
    tick(5);
    check("pre_tmo_period", period, 10);
    tick(247);
    check("tmo_early", timeout, 0);
    tick(1);
    check("tmo_set", timeout, 1);
    s0 = strobes;
    tick(40);
    check("tmo_sticky", timeout, 1);
    check("tmo_period_hold", period, 10);
    check("tmo_no_strobe", strobes, s0);
    wave(5, 1);
    check("tmo_cleared", timeout, 0);
    check("tmo_clear_no_strobe", strobes, s0);
    wave(5, 1);
    check("tmo_recover_strobe", strobes, s0 + 1);
    check("tmo_recover_period", last_period, 10);

    // 5: rises exactly 255 apart
    t0 = tmo_cycles;
    sigIn = 1'b1;
    tick(5);
    sigIn = 1'b0;
    tick(250);
    wave(5, 1);
    check("max_period", last_period, 255);
    check("max_high", last_high, DUTY ? 5 : 0);
    check("max_no_timeout", tmo_cycles - t0, 0);
    check("max_timeout_now", timeout, 0);

    // 6: reset pulse mid-period
    sigIn = 1'b1;
    tick(5);
    sigIn = 1'b0;
    tick(2);
    reset = 1'b0;
    #1;
    check("mid_rst_period", period, 0);
    check("mid_rst_high", highTime, 0);
    check("mid_rst_valid", periodValid, 0);
    check("mid_rst_timeout", timeout, 0);
    tick(1);
    reset = 1'b1;
    s0 = strobes;
    tick(3);
    wave(5, 1);
    check("mid_rst_first_rise", strobes, s0);
    check("mid_rst_period_hold", period, 0);
    wave(5, 1);
    check("mid_rst_second_rise", strobes, s0 + 1);
    check("mid_rst_new_period", last_period, 10);
    check("mid_rst_new_high", last_high, DUTY ? 5 : 0);

    check("no_double_strobe", dbl_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
